cr_aomux_reg: RTL and testbench
===============================

Name: cr_aomux_reg

Overview:
- Parametrised, registered AND-OR multiplexer: the successor to the fixed two-term AND-OR mux primitive.
- Selects one of N_CH data channels of DW bits using a one-hot select, then passes the result through one valid/ready pipeline stage.
- Checks each accepted select for one-hot legality and keeps a sticky error flag plus a saturating error counter.
- Used wherever a datapath steering point must be timing-isolated and its select integrity monitored.

Parameters:
- N_CH, 4, number of input channels (2..32).
- DW, 32, data width per channel (1..512).
- CNT_W, 8, width of the saturating select-error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  input beat valid.
- in_rdy  output  1  stage can accept a beat.
- in_sel  input  N_CH  one-hot channel select; bit i selects channel i.
- in_data  input  N_CH*DW  packed channel data; channel i occupies bits [i*DW +: DW].
- out_vld  output  1  output beat valid.
- out_rdy  input  1  downstream accepts the beat.
- out_data  output  DW  registered mux result.
- out_sel_err  output  1  the beat currently held on out_data had an illegal select.
- err_sticky  output  1  set by any illegal select accepted since reset or the last err_clr.
- err_cnt  output  CNT_W  count of illegal selects accepted, saturating.
- err_clr  input  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. Asserting rst_n low immediately forces out_vld=0, out_data=0, out_sel_err=0, err_sticky=0, err_cnt=0. Deassertion is synchronous to clk (synchronised externally).
- Combinational select: mux_d is the OR over i of (in_data channel i AND replicate(in_sel[i])).
  - Zero select gives mux_d = 0.
  - Multi-hot select gives the bitwise OR of all selected channels. There is no priority.
- Legality: illegal = (in_sel == 0) OR (more than one bit of in_sel set).
- Handshake: in_rdy = ~out_vld | out_rdy. This is combinational from out_vld and out_rdy; there is no combinational path from in_vld to in_rdy.
- Accept: accept = in_vld & in_rdy.
  - On accept: out_data <= mux_d, out_sel_err <= illegal, out_vld <= 1.
  - If out_vld & out_rdy and there is no accept: out_vld <= 0. out_data and out_sel_err hold their last values.
  - Otherwise all three hold.
- Latency: exactly 1 cycle from accept to out_vld. Full throughput is 1 beat per cycle while out_rdy=1.
- Backpressure: while out_vld=1 and out_rdy=0, out_data and out_sel_err stay stable and in_rdy=0. Inputs are ignored.
- in_sel and in_data are don't-care when in_vld=0. Illegal selects are counted only on accept.
- Error counter:
  - On accept & illegal: err_sticky <= 1 and err_cnt <= err_cnt + 1, saturating at 2^CNT_W - 1 (no wrap).
  - err_clr alone: err_sticky <= 0, err_cnt <= 0.
  - err_clr together with accept & illegal in the same cycle: the clear applies first, then the new event, giving err_sticky=1 and err_cnt=1.
- Reset mid-transfer: a held beat is discarded and out_vld drops asynchronously. No beat is replayed after reset.
- No storage beyond one beat; this is not a skid buffer.

Test Plan:
- Basic select: N_CH=4, DW=32, out_rdy=1. Send in_sel=4'b0100 with channel 2 = 0xDEADBEEF and other channels = 0xFFFFFFFF -> next cycle out_vld=1, out_data=0xDEADBEEF, out_sel_err=0, err_cnt=0.
- Multi-hot and zero select:
  - in_sel=4'b0011, ch0=0x0000_00F0, ch1=0x0000_0F00 -> out_data=0x0000_0FF0, out_sel_err=1.
  - Then in_sel=4'b0000 -> out_data=0, out_sel_err=1.
  - After both: err_sticky=1, err_cnt=2.
- Backpressure: out_rdy=0 for 5 cycles with in_vld=1 and changing data. First beat 0x11 is held stable for all 5 cycles and in_rdy=0. When out_rdy rises, 0x11 transfers and the next accepted beat appears the following cycle. There is no loss or duplication over a 100-beat random ready/valid run, checked against a reference queue.
- Saturation: CNT_W=3 with 10 accepted illegal selects -> err_cnt stops at 7 and does not wrap.
- Clear collision:
  - err_clr together with an accepted illegal beat -> err_cnt=1, err_sticky=1.
  - err_clr alone one cycle later -> err_cnt=0, err_sticky=0.
- Async reset: drop rst_n mid-cycle while out_vld=1 and out_rdy=0 -> out_vld, out_data, err_cnt and err_sticky all reach 0 before the next clk edge. After reset, in_rdy=1.

Source files
------------

// File: rtl/cr_aomux_reg.sv
// Registered one-hot AND-OR multiplexer with a single valid/ready stage.
// Every accepted select is checked for one-hot legality; errors feed a sticky flag and a saturating counter.
module cr_aomux_reg #(
    parameter int N_CH  = 4,
    parameter int DW    = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [N_CH-1:0]      in_sel,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DW-1:0]        out_data,
    output logic                 out_sel_err,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 err_clr
);

    localparam logic [N_CH-1:0]  SEL_ONE = N_CH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DW-1:0]    masked [N_CH];
    logic [DW-1:0]    mux_d;
    logic             illegal;
    logic             accept;

    logic             out_vld_q,     out_vld_d;
    logic [DW-1:0]    out_data_q,    out_data_d;
    logic             out_sel_err_q, out_sel_err_d;
    logic             err_sticky_q,  err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q,     err_cnt_d;
    logic [CNT_W-1:0] cnt_base;

    // Each channel is gated by its own select bit; no priority between channels.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign masked[gi] = in_data[gi*DW +: DW] & {DW{in_sel[gi]}};
        end
    endgenerate

    always_comb begin
        mux_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            mux_d = mux_d | masked[i];
        end
    end

    // x & (x-1) clears the lowest set bit, so a non-zero result means multi-hot.
    assign illegal = (in_sel == '0) || ((in_sel & (in_sel - SEL_ONE)) != '0);

    assign in_rdy = ~out_vld_q | out_rdy;
    assign accept = in_vld & in_rdy;

    always_comb begin
        out_vld_d     = out_vld_q;
        out_data_d    = out_data_q;
        out_sel_err_d = out_sel_err_q;
        if (accept) begin
            out_vld_d     = 1'b1;
            out_data_d    = mux_d;
            out_sel_err_d = illegal;
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Clear takes effect first so a same-cycle error event lands on a zeroed counter.
    always_comb begin
        cnt_base     = err_clr ? '0 : err_cnt_q;
        err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
        err_cnt_d    = cnt_base;
        if (accept && illegal) begin
            err_sticky_d = 1'b1;
            err_cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q     <= 1'b0;
            out_data_q    <= '0;
            out_sel_err_q <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            out_vld_q     <= out_vld_d;
            out_data_q    <= out_data_d;
            out_sel_err_q <= out_sel_err_d;
            err_sticky_q  <= err_sticky_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign out_vld     = out_vld_q;
    assign out_data    = out_data_q;
    assign out_sel_err = out_sel_err_q;
    assign err_sticky  = err_sticky_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cr_aomux_reg.sv
// Scoreboard bench for cr_aomux_reg: accepted beats queue their expected output, a monitor pops on transfer.
// A second narrow-counter instance exercises error-counter saturation.
module tb_cr_aomux_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [3:0]  in_sel = '0;
    logic [127:0] in_data = '0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] out_data;
    logic        out_sel_err;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic        err_clr = 1'b0;

    logic        s_in_vld = 1'b0;
    logic        s_in_rdy;
    logic [3:0]  s_in_sel = '0;
    logic [31:0] s_in_data = '0;
    logic        s_out_vld;
    logic [7:0]  s_out_data;
    logic        s_out_sel_err;
    logic        s_err_sticky;
    logic [2:0]  s_err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    cr_aomux_reg #(.N_CH(4), .DW(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_sel(in_sel),
        .in_data(in_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_sel_err(out_sel_err), .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    cr_aomux_reg #(.N_CH(4), .DW(8), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_vld(s_in_vld), .in_rdy(s_in_rdy), .in_sel(s_in_sel),
        .in_data(s_in_data), .out_vld(s_out_vld), .out_rdy(1'b1), .out_data(s_out_data),
        .out_sel_err(s_out_sel_err), .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .err_clr(1'b0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic set_ch(input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] c3);
        in_data = {c3, c2, c1, c0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat until accepted, queue its expected output, then leave in_vld low.
    task automatic send(input logic [3:0] sel, input logic [31:0] exp_data, input logic exp_err);
        bit done = 0;
        in_vld = 1'b1;
        in_sel = sel;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_rdy) begin
                exp_q.push_back({exp_err, exp_data});
                done = 1;
            end
            step();
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_vld = 1'b0;
    endtask

    // Monitor: every transferred beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_beat", {32'd0, out_data}, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("mon_data", {32'd0, out_data}, {32'd0, e[31:0]});
                chk("mon_sel_err", {63'd0, out_sel_err}, {63'd0, e[32]});
            end
        end
    end

    initial begin
        logic [31:0] ch [4];
        int accepted;
        int budget;

        #3;
        @(negedge clk);
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
        chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Basic one-hot select
        set_ch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        send(4'b0100, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("basic_out_vld", {63'd0, out_vld}, 64'd1);
        chk("basic_out_data", {32'd0, out_data}, 64'hDEAD_BEEF);
        chk("basic_err_cnt", {56'd0, err_cnt}, 64'd0);
        step();

        // Multi-hot ORs channels; zero select yields zero
        set_ch(32'h0000_00F0, 32'h0000_0F00, 32'h1234_5678, 32'h8765_4321);
        send(4'b0011, 32'h0000_0FF0, 1'b1);
        send(4'b0000, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("illegal_sticky", {63'd0, err_sticky}, 64'd1);
        chk("illegal_cnt", {56'd0, err_cnt}, 64'd2);
        step();

        // Clear collides with an accepted illegal beat, then clear alone
        err_clr = 1'b1;
        in_vld  = 1'b1;
        in_sel  = 4'b1111;
        set_ch(32'h1, 32'h2, 32'h4, 32'h8);
        @(negedge clk);
        chk("collide_in_rdy", {63'd0, in_rdy}, 64'd1);
        exp_q.push_back({1'b1, 32'hF});
        step();
        in_vld = 1'b0;
        @(negedge clk);
        chk("collide_cnt", {56'd0, err_cnt}, 64'd1);
        chk("collide_sticky", {63'd0, err_sticky}, 64'd1);
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clear_cnt", {56'd0, err_cnt}, 64'd0);
        chk("clear_sticky", {63'd0, err_sticky}, 64'd0);
        step();
        step();

        // Backpressure: first beat held while out_rdy is low
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_sel  = 4'b0001;
        set_ch(32'h11, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("bp_first_rdy", {63'd0, in_rdy}, 64'd1);
        exp_q.push_back({1'b0, 32'h11});
        for (int c = 0; c < 5; c++) begin
            step();
            set_ch(32'h20 + 32'(c), 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            chk("bp_hold_data", {32'd0, out_data}, 64'h11);
            chk("bp_hold_rdy", {63'd0, in_rdy}, 64'd0);
        end
        step();
        out_rdy = 1'b1;
        set_ch(32'h22, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("bp_release_rdy", {63'd0, in_rdy}, 64'd1);
        exp_q.push_back({1'b0, 32'h22});
        step();
        in_vld = 1'b0;
        @(negedge clk);
        chk("bp_next_data", {32'd0, out_data}, 64'h22);
        step();

        // Random valid/ready run with legal selects
        accepted = 0;
        budget = 0;
        while (accepted < 100 && budget < 3000) begin
            int idx;
            in_vld  = 1'($urandom);
            out_rdy = 1'($urandom);
            idx = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) ch[i] = $urandom;
            set_ch(ch[0], ch[1], ch[2], ch[3]);
            in_sel = 4'b0001 << idx;
            @(negedge clk);
            if (in_vld && in_rdy) begin
                exp_q.push_back({1'b0, ch[idx]});
                accepted++;
            end
            step();
            budget++;
        end
        chk("rand_all_accepted", 64'(accepted), 64'd100);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (3) step();
        chk("rand_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_err_cnt", {56'd0, err_cnt}, 64'd0);

        // Saturation on a 3-bit counter
        s_in_vld  = 1'b1;
        s_in_sel  = 4'b0000;
        s_in_data = 32'hA5A5_A5A5;
        for (int k = 1; k <= 10; k++) begin
            step();
            @(negedge clk);
            chk("sat_cnt", {61'd0, s_err_cnt}, (k > 7) ? 64'd7 : 64'(k));
        end
        s_in_vld = 1'b0;
        chk("sat_sticky", {63'd0, s_err_sticky}, 64'd1);
        step();

        // Async reset while a beat is held under backpressure
        set_ch(32'h0, 32'h0, 32'h0, 32'h0);
        send(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        step();
        out_rdy = 1'b0;
        set_ch(32'h55, 32'h0, 32'h0, 32'h0);
        send(4'b0001, 32'h55, 1'b0);
        @(negedge clk);
        chk("pre_rst_out_vld", {63'd0, out_vld}, 64'd1);
        chk("pre_rst_err_cnt", {56'd0, err_cnt}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_err_cnt", {56'd0, err_cnt}, 64'd0);
        chk("arst_err_sticky", {63'd0, err_sticky}, 64'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        out_rdy = 1'b1;
        repeat (2) step();
        chk("post_rst_out_vld", {63'd0, out_vld}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
